dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Purpose : arbitrates one single-port data memory between a CPU core and a host/debug port.
// Latency : grant one cycle after a request from IDLE, zero-gap handover; read data one cycle after accept.
// Backpres: a requester holds req/we/addr/wdata until its grant cycle; the owner yields after MAX_HOLD
//           accepted transfers when the other side is waiting.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU transfer request (held until accepted)
//   cpu_gnt, cpu_rvalid           CPU owns the port / CPU read data valid on rdata_out
//   host_req/we/addr/wdata        host transfer request (held until accepted)
//   host_gnt, host_rvalid         host owns the port / host read data valid on rdata_out
//   mem_we, mem_addr, mem_wdata   memory strobe/address/data, zero outside accepting cycles
//   mem_rdata, rdata_out          memory read data (1-cycle latency), passed straight through
module dmem_port_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [11:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata_out
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_OWN_CPU  = 2'd1;
    localparam logic [1:0] ST_OWN_HOST = 2'd2;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    // Count value at which the owner's next accepted transfer is its last under contention.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       last_owner_q, last_owner_d;
    logic       cpu_rvalid_q, host_rvalid_q;

    logic cpu_acc;
    logic host_acc;

    assign cpu_acc  = (state_q == ST_OWN_CPU)  && cpu_req;
    assign host_acc = (state_q == ST_OWN_HOST) && host_req;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req && host_req) begin
                    // Tie goes to whoever did not own the port last.
                    state_d = (last_owner_q == OWNER_HOST) ? ST_OWN_CPU : ST_OWN_HOST;
                end else if (cpu_req) begin
                    state_d = ST_OWN_CPU;
                end else if (host_req) begin
                    state_d = ST_OWN_HOST;
                end
            end
            ST_OWN_CPU: begin
                if (!cpu_req) begin
                    state_d = host_req ? ST_OWN_HOST : ST_IDLE;
                end else if (host_req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = ST_OWN_HOST;
                end
            end
            ST_OWN_HOST: begin
                if (!host_req) begin
                    state_d = cpu_req ? ST_OWN_CPU : ST_IDLE;
                end else if (cpu_req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = ST_OWN_CPU;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The counter saturates at HOLD_LAST so an uncontended owner yields on the
        // very next transfer once the other side starts waiting.
        if ((state_d != state_q) || (state_d == ST_IDLE)) begin
            hold_cnt_d = 4'd0;
        end else if ((cpu_acc || host_acc) && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end

        if (state_d != state_q) begin
            if (state_d == ST_OWN_CPU) begin
                last_owner_d = OWNER_CPU;
            end else if (state_d == ST_OWN_HOST) begin
                last_owner_d = OWNER_HOST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= 4'd0;
            last_owner_q  <= OWNER_HOST;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            last_owner_q  <= last_owner_d;
            // rvalid tags the issuer at accept time, so a handover on the same edge
            // cannot redirect the returning data.
            cpu_rvalid_q  <= cpu_acc && !cpu_we;
            host_rvalid_q <= host_acc && !host_we;
        end
    end

    always_comb begin
        mem_addr  = 12'd0;
        mem_wdata = 32'd0;
        if (cpu_acc) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_acc) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign mem_we      = (cpu_acc && cpu_we) || (host_acc && host_we);
    assign cpu_gnt     = (state_q == ST_OWN_CPU);
    assign host_gnt    = (state_q == ST_OWN_HOST);
    assign cpu_rvalid  = cpu_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign rdata_out   = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose : directed and randomized checks of dmem_port_arbiter against a transaction-level model.
// Latency : n/a (testbench).
// Backpres: requesters hold their request until the model says it was accepted.
module tb_dmem_port_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [11:0] cpu_addr, host_addr;
    logic [31:0] cpu_wdata, host_wdata;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] rdata_out;

    int total = 0;
    int bad   = 0;

    // Behavioural single-port memory: unwritten words read back a known pattern.
    logic [31:0]   tb_mem [0:4095];
    logic [4095:0] wr_seen = '0;
    logic [31:0]   ref_mem [int];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rdata_out  (rdata_out)
    );

    function automatic logic [31:0] init_word(input logic [11:0] a);
        return 32'h5A00_0000 | {20'd0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr]  <= mem_wdata;
            wr_seen[mem_addr] <= 1'b1;
        end
        mem_rdata <= wr_seen[mem_addr] ? tb_mem[mem_addr] : init_word(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req  = 1'b0; cpu_we  = 1'b0; cpu_addr  = 12'd0; cpu_wdata  = 32'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 12'd0; host_wdata = 32'd0;
    endtask

    // Leaves the bench at the start of "cycle 0": reset just released, state IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b1; host_we = 1'b1;
        cpu_addr = 12'h123; host_addr = 12'h456;
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_gnt: cpu_gnt=%b host_gnt=%b expected 0 0", cpu_gnt, host_gnt);
        end
        total++;
        if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_rvalid: cpu=%b host=%b expected 0 0", cpu_rvalid, host_rvalid);
        end
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 12'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_mem: we=%b addr=%h wdata=%h expected 0 0 0", mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_noreq: cpu_gnt=%b host_gnt=%b expected 0 0", cpu_gnt, host_gnt);
        end
        tick();
    endtask

    // Both requesters read continuously: CPU 1-4, host 5-8, CPU 9-12, host 13.
    task automatic test_contention();
        logic exp_cg, exp_hg, exp_cr, exp_hr;
        logic [11:0] exp_addr;
        idle_inputs();
        cpu_req = 1'b1; host_req = 1'b1;
        cpu_addr = 12'h100; host_addr = 12'h200;
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            exp_cg = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
            exp_hg = (c >= 5 && c <= 8) || (c == 13);
            exp_cr = (c >= 2 && c <= 5) || (c >= 10 && c <= 13);
            exp_hr = (c >= 6 && c <= 9);
            exp_addr = exp_cg ? 12'h100 : (exp_hg ? 12'h200 : 12'h000);
            total++;
            if (cpu_gnt !== exp_cg || host_gnt !== exp_hg) begin
                bad++;
                $display("FAIL contention_gnt c=%0d: cpu=%b host=%b expected %b %b", c, cpu_gnt, host_gnt, exp_cg, exp_hg);
            end
            total++;
            if (cpu_rvalid !== exp_cr || host_rvalid !== exp_hr) begin
                bad++;
                $display("FAIL contention_rvalid c=%0d: cpu=%b host=%b expected %b %b", c, cpu_rvalid, host_rvalid, exp_cr, exp_hr);
            end
            total++;
            if (mem_addr !== exp_addr || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL contention_mem c=%0d: addr=%h we=%b expected %h 0", c, mem_addr, mem_we, exp_addr);
            end
            if (exp_cr || exp_hr) begin
                total++;
                if (rdata_out !== init_word(exp_cr ? 12'h100 : 12'h200)) begin
                    bad++;
                    $display("FAIL contention_rdata c=%0d: got %h expected %h", c, rdata_out, init_word(exp_cr ? 12'h100 : 12'h200));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        int we_cnt;
        idle_inputs();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'h0000_ABCD;
        we_cnt = 0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) we_cnt++;
            if (c == 1) begin
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 32'h0000_ABCD) begin
                    bad++;
                    $display("FAIL wr_strobe: we=%b addr=%h wdata=%h expected 1 010 0000abcd", mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 3) begin
                total++;
                if (host_gnt !== 1'b1 || host_rvalid !== 1'b0 || mem_addr !== 12'h010) begin
                    bad++;
                    $display("FAIL rd_accept: gnt=%b rvalid=%b addr=%h expected 1 0 010", host_gnt, host_rvalid, mem_addr);
                end
            end
            if (c == 4) begin
                total++;
                if (host_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || rdata_out !== 32'h0000_ABCD) begin
                    bad++;
                    $display("FAIL rd_data: host_rv=%b cpu_rv=%b rdata=%h expected 1 0 0000abcd", host_rvalid, cpu_rvalid, rdata_out);
                end
            end
            tick();
            if (c == 1) begin
                cpu_req = 1'b0; cpu_we = 1'b0;
                host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010;
            end
            if (c == 3) host_req = 1'b0;
        end
        total++;
        if (we_cnt != 1) begin
            bad++;
            $display("FAIL wr_once: mem_we pulses=%0d expected 1", we_cnt);
        end
        idle_inputs();
    endtask

    // Ten uncontended host reads; the saturated counter then yields on the next transfer.
    task automatic test_host_only();
        logic exp_hg, exp_cg, exp_hr;
        idle_inputs();
        do_reset();
        host_req = 1'b1; host_addr = 12'h300;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            exp_hg = (c >= 1 && c <= 10);
            exp_cg = (c == 11);
            exp_hr = (c >= 2 && c <= 11);
            total++;
            if (host_gnt !== exp_hg || cpu_gnt !== exp_cg) begin
                bad++;
                $display("FAIL host_hold_gnt c=%0d: host=%b cpu=%b expected %b %b", c, host_gnt, cpu_gnt, exp_hg, exp_cg);
            end
            total++;
            if (host_rvalid !== exp_hr || cpu_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL host_hold_rvalid c=%0d: host=%b cpu=%b expected %b 0", c, host_rvalid, cpu_rvalid, exp_hr);
            end
            tick();
            if (c == 9) begin
                cpu_req = 1'b1; cpu_addr = 12'h301;
            end
        end
        idle_inputs();
    endtask

    task automatic test_cpu_handover();
        idle_inputs();
        do_reset();
        cpu_req = 1'b1; cpu_addr = 12'h0A0;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 5) begin
                total++;
                if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin
                    bad++;
                    $display("FAIL handover_last c=5: cpu=%b host=%b expected 1 0", cpu_gnt, host_gnt);
                end
            end
            if (c == 6) begin
                total++;
                if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b1 || host_rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL handover_switch c=6: hgnt=%b cgnt=%b crv=%b hrv=%b expected 1 0 1 0", host_gnt, cpu_gnt, cpu_rvalid, host_rvalid);
                end
            end
            if (c == 7) begin
                total++;
                if (host_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL handover_rvalid c=7: hrv=%b crv=%b expected 1 0", host_rvalid, cpu_rvalid);
                end
            end
            tick();
            if (c == 4) begin
                host_req = 1'b1; host_addr = 12'h0B0;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        idle_inputs();
        do_reset();
        cpu_req = 1'b1; cpu_addr = 12'h040;
        tick();
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_accept: cpu_gnt=%b expected 1", cpu_gnt);
        end
        tick();
        rst_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_flush: crv=%b cgnt=%b hgnt=%b expected 0 0 0", cpu_rvalid, cpu_gnt, host_gnt);
        end
        tick();
        rst_n = 1'b1;
        host_req = 1'b1; host_addr = 12'h041;
        @(negedge clk);
        total++;
        if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_after: crv=%b cgnt=%b hgnt=%b expected 0 0 0", cpu_rvalid, cpu_gnt, host_gnt);
        end
        tick();
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_idle_grant: hgnt=%b cgnt=%b crv=%b expected 1 0 0", host_gnt, cpu_gnt, cpu_rvalid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_drop();
        idle_inputs();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h050; cpu_wdata = 32'h1234_5678;
        tick();
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'd0) begin
            bad++;
            $display("FAIL drop_owned: cgnt=%b we=%b addr=%h expected 1 0 000", cpu_gnt, mem_we, mem_addr);
        end
        tick();
        @(negedge clk);
        total++;
        if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || mem_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL drop_idle: cgnt=%b hgnt=%b we=%b crv=%b expected 0 0 0 0", cpu_gnt, host_gnt, mem_we, cpu_rvalid);
        end
        tick();
    endtask

    // Transaction model: owner keeps the port until it stops requesting or has served
    // MAX_HOLD transfers in its current tenure while the other side is waiting.
    task automatic test_random();
        int owner, last, served, pend, new_pend, new_owner;
        logic acc_c, acc_h, own_req, other_req, exp_we;
        logic [11:0] exp_addr, a;
        logic [31:0] exp_wd, pend_data;
        idle_inputs();
        do_reset();
        ref_mem.delete();
        owner = 0; last = 2; served = 0; pend = 0; pend_data = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc_c = (owner == 1) && cpu_req;
            acc_h = (owner == 2) && host_req;
            exp_we   = (acc_c && cpu_we) || (acc_h && host_we);
            exp_addr = acc_c ? cpu_addr : (acc_h ? host_addr : 12'd0);
            exp_wd   = acc_c ? cpu_wdata : (acc_h ? host_wdata : 32'd0);
            total++;
            if (cpu_gnt !== (owner == 1) || host_gnt !== (owner == 2)) begin
                bad++;
                $display("FAIL rnd_gnt n=%0d: cpu=%b host=%b expected owner %0d", n, cpu_gnt, host_gnt, owner);
            end
            total++;
            if (cpu_rvalid !== (pend == 1) || host_rvalid !== (pend == 2)) begin
                bad++;
                $display("FAIL rnd_rvalid n=%0d: cpu=%b host=%b expected issuer %0d", n, cpu_rvalid, host_rvalid, pend);
            end
            total++;
            if (mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
                bad++;
                $display("FAIL rnd_mem n=%0d: we=%b addr=%h wd=%h expected %b %h %h", n, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wd);
            end
            if (pend != 0) begin
                total++;
                if (rdata_out !== pend_data) begin
                    bad++;
                    $display("FAIL rnd_rdata n=%0d: got %h expected %h", n, rdata_out, pend_data);
                end
            end

            new_pend = 0;
            if (acc_c || acc_h) begin
                a = exp_addr;
                if (exp_we) begin
                    ref_mem[int'(a)] = exp_wd;
                end else begin
                    new_pend  = owner;
                    pend_data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
                end
            end
            pend = new_pend;

            own_req   = (owner == 1) ? cpu_req : ((owner == 2) ? host_req : 1'b0);
            other_req = (owner == 1) ? host_req : ((owner == 2) ? cpu_req : 1'b0);
            if (owner == 0) begin
                if (cpu_req && host_req) new_owner = (last == 1) ? 2 : 1;
                else if (cpu_req)        new_owner = 1;
                else if (host_req)       new_owner = 2;
                else                     new_owner = 0;
            end else if (!own_req) begin
                new_owner = other_req ? (3 - owner) : 0;
            end else if (other_req && (served + 1 >= MAX_HOLD)) begin
                new_owner = 3 - owner;
            end else begin
                new_owner = owner;
            end
            if (new_owner != owner) begin
                served = 0;
                if (new_owner != 0) last = new_owner;
            end else if (acc_c || acc_h) begin
                served = served + 1;
            end
            owner = new_owner;

            tick();
            if (acc_c) cpu_req = 1'b0;
            if (acc_h) host_req = 1'b0;
            if (!cpu_req && $urandom_range(0, 3) != 0) begin
                cpu_req   = 1'b1;
                cpu_we    = ($urandom_range(0, 2) == 0);
                cpu_addr  = 12'h020 + 12'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!host_req && $urandom_range(0, 1) != 0) begin
                host_req   = 1'b1;
                host_we    = ($urandom_range(0, 2) == 0);
                host_addr  = 12'h020 + 12'($urandom_range(0, 15));
                host_wdata = $urandom;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_contention();
        test_write_read();
        test_host_only();
        test_cpu_handover();
        test_reset_mid_read();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
